// File: rtl/axi_stream_word_to_byte.sv
// ---------------------------------------------------------------------------
// axi_stream_word_to_byte
//
// Purpose:
//   Takes DATA_WIDTH-bit words from an AXI-stream slave port and sends each
//   one out as DATA_WIDTH/8 bytes on an 8-bit AXI-stream master port, for
//   example toward a UART transmitter. It sustains one byte per cycle, and
//   the next word follows the last byte of the current word with no bubble.
//   The final byte of each word is flagged with m_axis_last.
//
// Parameters:
//   DATA_WIDTH - input word width (a multiple of 8, at least 16)
//   MSB_FIRST  - 0: bits [7:0] are sent first; 1: the most significant byte
//                is sent first
//
// Ports:
//   axi_clk      - clock; all logic runs on the rising edge
//   axi_reset    - synchronous, active-high reset
//   s_axis_valid - input word valid
//   s_axis_data  - input word
//   s_axis_ready - the block accepts a word this cycle
//   m_axis_valid - output byte valid (registered)
//   m_axis_data  - output byte (registered)
//   m_axis_last  - set with the final byte of each word (registered)
//   m_axis_ready - downstream accepts a byte
//   o_busy       - a word is being serialised
// ---------------------------------------------------------------------------
module axi_stream_word_to_byte #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [7:0]            m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  o_busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(BYTES - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state;
  logic [CW-1:0]           count;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   shifted;
  logic                    s_xfer;
  logic                    m_xfer;
  logic                    on_last;

  // The byte that goes out first is always at the same end of the shift
  // register; shifting walks the remaining bytes toward that end.
  function automatic logic [7:0] lead_byte(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[DATA_WIDTH-1 -: 8];
    end
    return w[7:0];
  endfunction

  // Handshake decode. Ready depends only on state and m_axis_ready, so a new
  // word is taken exactly when the final byte of the current one leaves.
  always_comb begin
    on_last      = (state == SEND) && (count == LAST_COUNT);
    s_axis_ready = ~axi_reset & ((state == IDLE) | (on_last & m_axis_ready));
    s_xfer       = s_axis_valid & s_axis_ready;
    m_xfer       = m_axis_valid & m_axis_ready;
    shifted      = MSB_FIRST ? (shift_reg << 8) : (shift_reg >> 8);
    o_busy       = (state == SEND);
  end

  // Serialiser FSM. Output byte and last flag are registered so that they
  // are already stable in the cycle after a word is accepted and hold
  // unchanged for as long as the downstream stalls.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state        <= IDLE;
      count        <= '0;
      shift_reg    <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= 8'h00;
      m_axis_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_xfer) begin
            state        <= SEND;
            count        <= '0;
            shift_reg    <= s_axis_data;
            m_axis_valid <= 1'b1;
            m_axis_data  <= lead_byte(s_axis_data);
            m_axis_last  <= 1'b0;
          end
        end
        SEND: begin
          if (m_xfer) begin
            if (count == LAST_COUNT) begin
              // Reload in place for a zero-bubble hand-over to the next word.
              if (s_xfer) begin
                count        <= '0;
                shift_reg    <= s_axis_data;
                m_axis_data  <= lead_byte(s_axis_data);
                m_axis_last  <= 1'b0;
              end else begin
                state        <= IDLE;
                m_axis_valid <= 1'b0;
                m_axis_last  <= 1'b0;
              end
            end else begin
              count       <= count + 1'b1;
              shift_reg   <= shifted;
              m_axis_data <= lead_byte(shifted);
              m_axis_last <= ((count + 1'b1) == LAST_COUNT);
            end
          end
        end
        default: begin
          state        <= IDLE;
          m_axis_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_word_to_byte.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_word_to_byte
//
// Drives one LSB-first and one MSB-first instance with the same stimulus.
// Every accepted word is expanded by a byte-list reference model into a
// per-instance expected queue; a monitor on the falling edge compares the
// presented byte, last flag, valid and s_axis_ready against that queue.
// ---------------------------------------------------------------------------
module tb_axi_stream_word_to_byte;

  logic        axi_clk;
  logic        axi_reset;
  logic        s_valid;
  logic [31:0] s_data;
  logic        m_ready;
  logic        s_ready [2];
  logic        m_valid [2];
  logic [7:0]  m_data  [2];
  logic        m_last  [2];
  logic        busy    [2];

  int total;
  int bad;

  // expected bytes per instance: {last, data}
  logic [8:0] expq [2][$];

  logic rst_edge;
  int   ready_mode;
  int   pat_idx;

  axi_stream_word_to_byte #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .s_axis_valid (s_valid),
    .s_axis_data  (s_data),
    .s_axis_ready (s_ready[0]),
    .m_axis_valid (m_valid[0]),
    .m_axis_data  (m_data[0]),
    .m_axis_last  (m_last[0]),
    .m_axis_ready (m_ready),
    .o_busy       (busy[0])
  );

  axi_stream_word_to_byte #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .s_axis_valid (s_valid),
    .s_axis_data  (s_data),
    .s_axis_ready (s_ready[1]),
    .m_axis_valid (m_valid[1]),
    .m_axis_data  (m_data[1]),
    .m_axis_last  (m_last[1]),
    .m_axis_ready (m_ready),
    .o_busy       (busy[1])
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  always @(posedge axi_clk) rst_edge <= axi_reset;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: word split into bytes, byte i of the stream is the
  // i-th least (or most) significant byte, the fourth one carries last.
  task automatic modelPush(input int d, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      int sh;
      logic [7:0] b;
      sh = (d == 0) ? 8 * i : 8 * (3 - i);
      b  = 8'((word >> sh) & 32'hFF);
      expq[d].push_back({(i == 3), b});
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge where inputs are stable.
  always @(negedge axi_clk) begin
    for (int d = 0; d < 2; d++) begin
      string tag;
      tag = (d == 0) ? "lsb" : "msb";
      if (rst_edge) begin
        checkOutput({tag, "_rst_valid"}, 32'(m_valid[d]), 32'd0);
        checkOutput({tag, "_rst_data"},  32'(m_data[d]),  32'd0);
        checkOutput({tag, "_rst_last"},  32'(m_last[d]),  32'd0);
      end
      if (axi_reset) begin
        checkOutput({tag, "_rst_ready"}, 32'(s_ready[d]), 32'd0);
        expq[d].delete();
      end else begin
        logic exp_ready;
        exp_ready = (expq[d].size() == 0) || ((expq[d].size() == 1) && m_ready);
        checkOutput({tag, "_s_ready"}, 32'(s_ready[d]), 32'(exp_ready));
        if (expq[d].size() > 0) begin
          checkOutput({tag, "_valid"}, 32'(m_valid[d]), 32'd1);
          checkOutput({tag, "_data"},  32'(m_data[d]),  32'(expq[d][0][7:0]));
          checkOutput({tag, "_last"},  32'(m_last[d]),  32'(expq[d][0][8]));
          if (m_ready && m_valid[d]) void'(expq[d].pop_front());
        end else begin
          checkOutput({tag, "_idle_valid"}, 32'(m_valid[d]), 32'd0);
        end
        if (s_valid && s_ready[d]) modelPush(d, s_data);
      end
    end
  end

  // Downstream ready driver: 0 always ready, 1 pattern 1,0,0, 2 random.
  always @(posedge axi_clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = (pat_idx % 3 == 0);
        pat_idx = pat_idx + 1;
      end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Offers a word and holds it until the LSB instance accepts it.
  task automatic applyStimulus(input logic [31:0] word);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = word;
    forever begin
      @(negedge axi_clk);
      if (s_ready[0]) break;
      n++;
      if (n > 200) begin
        bad++;
        $display("[TB] FAIL accept_timeout: word %0h not accepted, got ready=0, expected 1", word);
        break;
      end
    end
    @(posedge axi_clk);
    #1;
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expq[0].size() != 0 || expq[1].size() != 0 || m_valid[0] || m_valid[1]) begin
      @(negedge axi_clk);
      n++;
      if (n > 500) begin
        bad++;
        $display("[TB] FAIL drain_timeout: queue=%0d, expected 0", expq[0].size());
        break;
      end
    end
    @(posedge axi_clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    ready_mode = 0;
    pat_idx    = 0;
    m_ready    = 1'b1;
    s_data     = 32'hCAFE_F00D;

    // Reset held three cycles with a word offered.
    axi_reset = 1'b1;
    s_valid   = 1'b1;
    repeat (3) @(posedge axi_clk);
    #1;
    axi_reset = 1'b0;
    s_valid   = 1'b0;
    repeat (2) @(posedge axi_clk);
    #1;

    // Single word, always ready.
    applyStimulus(32'hDDCCBBAA);
    waitDrain();

    // Back-to-back words, zero bubble.
    applyStimulus(32'h03020100);
    applyStimulus(32'h07060504);
    waitDrain();

    // Backpressure pattern 1,0,0.
    pat_idx    = 0;
    ready_mode = 1;
    applyStimulus(32'h44332211);
    waitDrain();
    ready_mode = 0;
    @(posedge axi_clk);
    #1;

    applyStimulus(32'h12345678);
    waitDrain();

    // Reset after byte 1 of a word.
    applyStimulus(32'hDDCCBBAA);
    @(posedge axi_clk);
    @(posedge axi_clk);
    #1;
    axi_reset = 1'b1;
    repeat (2) @(posedge axi_clk);
    #1;
    axi_reset = 1'b0;
    applyStimulus(32'h00000055);
    waitDrain();

    // Random words, gaps and downstream stalls.
    ready_mode = 2;
    for (int w = 0; w < 40; w++) begin
      applyStimulus($urandom);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge axi_clk);
        #1;
      end
    end
    waitDrain();

    checkOutput("final_queue_lsb", 32'(expq[0].size()), 32'd0);
    checkOutput("final_queue_msb", 32'(expq[1].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: time=%0t, expected finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
